commit_trace_buffer: RTL and testbench

Synthesizable commit-trace collector sitting directly downstream of the `trivial_mips` write-back and memory stages. Each cycle it captures up to six architectural side effects (memory write, GPR write and HI/LO write for each of the two issue paths) in the fixed checker order. It stamps every record with a cycle number and queues the records in a circular buffer. It then drains them one per cycle over a valid/ready port to a trace consumer: the unit-test comparator or the UART dumper.

---
 rtl/cpu_defs.sv | 51 +++++
 rtl/trace_slot_pack.sv | 29 ++
 rtl/commit_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the commit-trace path.
// Latency: n/a (types, constants and a record constructor only).
// Backpressure: n/a.
package cpu_defs;

  localparam int TRACE_SLOTS = 6;
  // Enough bits to hold a slot count of 0..TRACE_SLOTS.
  localparam int SLOT_CNT_W  = $clog2(TRACE_SLOTS + 1);

  typedef struct packed {
    logic base;
    logic rst;
  } Clock_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;

  typedef struct packed {
    logic        we;
    logic [63:0] hilo;
  } HiloWriteReq_t;

  typedef enum logic [1:0] {
    TRACE_REG  = 2'd0,
    TRACE_HILO = 2'd1,
    TRACE_MEM  = 2'd2
  } TraceKind_t;

  typedef struct packed {
    TraceKind_t  kind;
    logic [31:0] cycle;
    logic [15:0] addr;
    logic [63:0] data;
  } TraceRec_t;

  function automatic TraceRec_t mk_trace_rec(input TraceKind_t  kind,
                                             input logic [31:0] cycle,
                                             input logic [15:0] addr,
                                             input logic [63:0] data);
    TraceRec_t r;
    r.kind  = kind;
    r.cycle = cycle;
    r.addr  = addr;
    r.data  = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_slot_pack.sv
// Compacts the valid trace slots of one cycle, preserving slot order.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: slot_vld/slot_rec in (TRACE_SLOTS each); pack_rec out (valid
// records first, in slot order, rest zero); pack_n out (number valid).
module trace_slot_pack
  import cpu_defs::*;
(
  input  logic      [TRACE_SLOTS-1:0] slot_vld,
  input  TraceRec_t [TRACE_SLOTS-1:0] slot_rec,
  output TraceRec_t [TRACE_SLOTS-1:0] pack_rec,
  output logic      [SLOT_CNT_W-1:0]  pack_n
);

  // Running prefix sum: pos is the number of valid slots below slot i,
  // which is exactly the output index of slot i when it is valid.
  always_comb begin
    logic [SLOT_CNT_W-1:0] pos;
    pos      = '0;
    pack_rec = '0;
    for (int i = 0; i < TRACE_SLOTS; i++) begin
      if (slot_vld[i]) begin
        pack_rec[pos] = slot_rec[i];
        pos           = pos + SLOT_CNT_W'(1);
      end
    end
    pack_n = pos;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace collector: captures up to six side effects per cycle, stamps
// them with a cycle number and queues them in a circular buffer.
// Latency: 1 cycle capture-to-out_valid when empty. Backpressure: valid/ready
// drain one record per cycle; a group that does not fit is dropped whole and
// counted; stall_req warns the CPU top level when fewer than 6 entries remain.
// Ports: clk (base clock + sync active-high rst), trace_en, reg_wr1/2,
// hilo_wr1/2, mem_we/mem_path1/mem_addr/mem_data in; out_rec/out_valid/
// out_ready consumer port; stall_req, overflow (sticky), drop_cnt status.
module commit_trace_buffer
  import cpu_defs::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  Clock_t            clk,
  input  logic              trace_en,
  input  RegWriteReq_t      reg_wr1,
  input  RegWriteReq_t      reg_wr2,
  input  HiloWriteReq_t     hilo_wr1,
  input  HiloWriteReq_t     hilo_wr2,
  input  logic              mem_we,
  input  logic              mem_path1,
  input  logic [15:0]       mem_addr,
  input  logic [31:0]       mem_data,
  output TraceRec_t         out_rec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stall_req,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;  // one extra bit so full and empty differ

  TraceRec_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           cyc_q, cyc_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [31:0]                  stamp;
  logic [TRACE_SLOTS-1:0]       slot_vld;
  TraceRec_t [TRACE_SLOTS-1:0]  slot_rec;
  TraceRec_t [TRACE_SLOTS-1:0]  pack_rec;
  logic [SLOT_CNT_W-1:0]        pack_n;
  logic [CW-1:0]                free_cnt;
  logic [CW-1:0]                n_ext;
  logic                         accept;
  logic                         pop;

  // Memory writes are traced word-aligned; the byte offset is discarded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Records captured on this edge carry the value the counter takes on it.
  assign stamp = cyc_q + 32'd1;

  // Slot map: 0..2 = path-1 mem/GPR/HILO, 3..5 = path-2 mem/GPR/HILO.
  // The single memory write lands in slot 0 or slot 3 by its owning path.
  always_comb begin
    TraceRec_t mem_rec;
    mem_rec = mk_trace_rec(TRACE_MEM, stamp, {mem_addr[15:2], 2'b00},
                           {32'h0, mem_data});
    slot_rec    = '0;
    slot_rec[0] = mem_rec;
    slot_rec[1] = mk_trace_rec(TRACE_REG, stamp, {11'h0, reg_wr1.waddr},
                               {32'h0, reg_wr1.wdata});
    slot_rec[2] = mk_trace_rec(TRACE_HILO, stamp, 16'h0, hilo_wr1.hilo);
    slot_rec[3] = mem_rec;
    slot_rec[4] = mk_trace_rec(TRACE_REG, stamp, {11'h0, reg_wr2.waddr},
                               {32'h0, reg_wr2.wdata});
    slot_rec[5] = mk_trace_rec(TRACE_HILO, stamp, 16'h0, hilo_wr2.hilo);

    slot_vld    = '0;
    slot_vld[0] = mem_we & mem_path1;
    slot_vld[1] = reg_wr1.we & (reg_wr1.waddr != 5'd0);  // $0 writes are no-ops
    slot_vld[2] = hilo_wr1.we;
    slot_vld[3] = mem_we & ~mem_path1;
    slot_vld[4] = reg_wr2.we & (reg_wr2.waddr != 5'd0);
    slot_vld[5] = hilo_wr2.we;
    if (!trace_en) begin
      slot_vld = '0;
    end
  end

  trace_slot_pack u_pack (
    .slot_vld (slot_vld),
    .slot_rec (slot_rec),
    .pack_rec (pack_rec),
    .pack_n   (pack_n)
  );

  // Admission uses the registered count: an entry freed by this cycle's pop
  // is not reusable until the next cycle.
  assign free_cnt = CW'(DEPTH) - count_q;
  assign n_ext    = CW'(pack_n);
  assign accept   = (n_ext <= free_cnt);
  assign pop      = out_valid & out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cyc_d      = cyc_q + 32'd1;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q - CW'(pop);

    if (accept) begin
      for (int i = 0; i < TRACE_SLOTS; i++) begin
        if (i < int'(pack_n)) begin
          mem_d[wr_ptr_q + PW'(i)] = pack_rec[i];
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(pack_n);
      count_d  = count_q + n_ext - CW'(pop);
    end else begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk.base) begin
    if (clk.rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q, which
  // is cleared, so data written during reset is never presented.
  always_ff @(posedge clk.base) begin
    mem_q <= mem_d;
  end

  // Head entry is never overwritten while queued, so out_rec holds under
  // backpressure; it reads as zero when the buffer is empty.
  assign out_valid = (count_q != '0);
  assign out_rec   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign stall_req = (free_cnt < CW'(6));
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  import cpu_defs::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic              clk_base = 1'b0;
  logic              rst = 1'b1;
  Clock_t            clk;
  logic              trace_en;
  RegWriteReq_t      reg_wr1, reg_wr2;
  HiloWriteReq_t     hilo_wr1, hilo_wr2;
  logic              mem_we, mem_path1;
  logic [15:0]       mem_addr;
  logic [31:0]       mem_data;
  TraceRec_t         out_rec;
  logic              out_valid;
  logic              out_ready;
  logic              stall_req;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  assign clk.base = clk_base;
  assign clk.rst  = rst;

  always #5 clk_base = ~clk_base;

  commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .trace_en  (trace_en),
    .reg_wr1   (reg_wr1),
    .reg_wr2   (reg_wr2),
    .hilo_wr1  (hilo_wr1),
    .hilo_wr2  (hilo_wr2),
    .mem_we    (mem_we),
    .mem_path1 (mem_path1),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_rec   (out_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall_req (stall_req),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain FIFO of expected records plus status values.
  TraceRec_t         exp_q[$];
  logic [31:0]       m_cyc = '0;
  logic              m_ovf = 1'b0;
  logic [DROP_W-1:0] m_drop = '0;
  bit                chk_en = 1'b0;
  bit                mon_en = 1'b0;
  logic [31:0]       last_stamp = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic TraceRec_t mkr(input TraceKind_t k, input logic [31:0] c,
                                    input logic [15:0] a, input logic [63:0] d);
    TraceRec_t r;
    r.kind  = k;
    r.cycle = c;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    chk("out_valid", 128'(out_valid), 128'(sz != 0));
    if (sz != 0) chk("out_rec", 128'(out_rec), 128'(exp_q[0]));
    chk("stall_req", 128'(stall_req), 128'((DEPTH - sz) < 6));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    if (mon_en && out_valid && out_ready) begin
      chk("stamp_incr", 128'(out_rec.cycle > last_stamp), 128'(1));
      last_stamp = out_rec.cycle;
    end
  endtask

  // Applies the rules to the inputs currently driven, as of the next edge.
  task automatic model_step();
    TraceRec_t   grp[$];
    logic [31:0] st;
    int          free_n;
    if (rst) begin
      exp_q.delete();
      m_cyc  = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
    end else begin
      st = m_cyc + 32'd1;
      if (trace_en) begin
        if (mem_we && mem_path1)
          grp.push_back(mkr(TRACE_MEM, st, {mem_addr[15:2], 2'b00}, {32'h0, mem_data}));
        if (reg_wr1.we && reg_wr1.waddr != 0)
          grp.push_back(mkr(TRACE_REG, st, {11'h0, reg_wr1.waddr}, {32'h0, reg_wr1.wdata}));
        if (hilo_wr1.we)
          grp.push_back(mkr(TRACE_HILO, st, 16'h0, hilo_wr1.hilo));
        if (mem_we && !mem_path1)
          grp.push_back(mkr(TRACE_MEM, st, {mem_addr[15:2], 2'b00}, {32'h0, mem_data}));
        if (reg_wr2.we && reg_wr2.waddr != 0)
          grp.push_back(mkr(TRACE_REG, st, {11'h0, reg_wr2.waddr}, {32'h0, reg_wr2.wdata}));
        if (hilo_wr2.we)
          grp.push_back(mkr(TRACE_HILO, st, 16'h0, hilo_wr2.hilo));
      end
      free_n = DEPTH - exp_q.size();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (grp.size() <= free_n) begin
        foreach (grp[i]) exp_q.push_back(grp[i]);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != '1) m_drop = m_drop + 1'b1;
      end
      m_cyc = st;
    end
  endtask

  task automatic tick();
    #3;
    if (chk_en) check_outputs();
    model_step();
    @(posedge clk_base);
    #1;
  endtask

  task automatic idle();
    trace_en  = 1'b1;
    reg_wr1   = '{we: 1'b0, waddr: 5'($urandom_range(0, 31)), wdata: $urandom()};
    reg_wr2   = '{we: 1'b0, waddr: 5'($urandom_range(0, 31)), wdata: $urandom()};
    hilo_wr1  = '{we: 1'b0, hilo: {$urandom(), $urandom()}};
    hilo_wr2  = '{we: 1'b0, hilo: {$urandom(), $urandom()}};
    mem_we    = 1'b0;
    mem_path1 = 1'($urandom_range(0, 1));
    mem_addr  = 16'($urandom());
    mem_data  = $urandom();
  endtask

  // Enables the first n (0..5) sources; at most five can coexist since
  // there is only one memory write per cycle.
  task automatic drive_n(input int n);
    idle();
    if (n > 0) begin reg_wr1.we = 1'b1;  reg_wr1.waddr = 5'($urandom_range(1, 31)); end
    if (n > 1) hilo_wr1.we = 1'b1;
    if (n > 2) begin reg_wr2.we = 1'b1;  reg_wr2.waddr = 5'($urandom_range(1, 31)); end
    if (n > 3) hilo_wr2.we = 1'b1;
    if (n > 4) mem_we = 1'b1;
  endtask

  task automatic drive_rand();
    idle();
    trace_en    = ($urandom_range(0, 7) != 0);
    reg_wr1.we  = 1'($urandom_range(0, 1));
    reg_wr2.we  = 1'($urandom_range(0, 1));
    hilo_wr1.we = 1'($urandom_range(0, 1));
    hilo_wr2.we = 1'($urandom_range(0, 1));
    mem_we      = 1'($urandom_range(0, 1));
  endtask

  TraceRec_t exp_ord[4];

  initial begin
    // Reset held 3 cycles with every source active.
    out_ready = 1'b1;
    drive_n(5);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_stall_req", 128'(stall_req), 128'(0));
      chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
    end
    rst = 1'b0;
    idle();
    tick();
    chk("post_rst_no_rec", 128'(out_valid), 128'(0));

    // Ordering: four records in checker order, all stamped 2.
    idle();
    out_ready = 1'b1;
    reg_wr1   = '{we: 1'b1, waddr: 5'd3, wdata: 32'h11};
    hilo_wr1  = '{we: 1'b1, hilo: 64'h1_0000_0002};
    mem_we    = 1'b1;
    mem_path1 = 1'b0;
    mem_addr  = 16'h0106;
    mem_data  = 32'h55;
    reg_wr2   = '{we: 1'b1, waddr: 5'd4, wdata: 32'h22};
    exp_ord[0] = mkr(TRACE_REG,  32'd2, 16'h0003, 64'h11);
    exp_ord[1] = mkr(TRACE_HILO, 32'd2, 16'h0000, 64'h1_0000_0002);
    exp_ord[2] = mkr(TRACE_MEM,  32'd2, 16'h0104, 64'h55);
    exp_ord[3] = mkr(TRACE_REG,  32'd2, 16'h0004, 64'h22);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order_rec%0d", k), 128'(out_rec), 128'(exp_ord[k]));
      tick();
    end
    chk("order_empty", 128'(out_valid), 128'(0));

    // Filtering: $0 write, then everything active with trace_en low.
    idle();
    reg_wr1 = '{we: 1'b1, waddr: 5'd0, wdata: 32'hdead_beef};
    tick();
    chk("filt_waddr0", 128'(out_valid), 128'(0));
    drive_n(5);
    trace_en = 1'b0;
    tick();
    chk("filt_trace_en", 128'(out_valid), 128'(0));

    // Backpressure and overflow.
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive_n(4);
      tick();
      if (g == 1) chk("bp_stall_at8", 128'(stall_req), 128'(0));
    end
    idle();
    chk("bp_stall_at12", 128'(stall_req), 128'(1));
    drive_n(5);
    tick();
    idle();
    chk("bp_overflow", 128'(overflow), 128'(1));
    chk("bp_drop_cnt", 128'(drop_cnt), 128'(1));
    out_ready = 1'b1;
    repeat (11) tick();
    chk("bp_drain11_valid", 128'(out_valid), 128'(1));
    tick();
    chk("bp_drain12_empty", 128'(out_valid), 128'(0));

    // Full buffer with simultaneous pop and a 1-record push.
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      drive_n(g < 3 ? 5 : 1);
      tick();
    end
    drive_n(1);
    out_ready = 1'b1;
    tick();
    idle();
    chk("full_drop_cnt", 128'(drop_cnt), 128'(2));
    repeat (14) tick();
    chk("full_left15_valid", 128'(out_valid), 128'(1));
    tick();
    chk("full_left15_empty", 128'(out_valid), 128'(0));

    // Wrap-around stream: pointers cycle the buffer more than twice.
    mon_en = 1'b1;
    last_stamp = '0;
    for (int i = 0; i < 40; i++) begin
      drive_n(1);
      out_ready = (i % 4 != 3);
      tick();
    end
    idle();
    out_ready = 1'b1;
    repeat (16) tick();
    mon_en = 1'b0;
    chk("wrap_no_loss", 128'(drop_cnt), 128'(2));
    chk("wrap_empty", 128'(out_valid), 128'(0));

    // Random traffic with occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      out_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (20) tick();
    chk("final_empty", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
